// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
// Packets carry a full 64-bit PC; narrower fetch_queue instances zero-extend into it.
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int PKT_ADDR_W = 64;
    localparam logic [10:0] HALT_OPC = 11'h7FF;

    typedef struct packed {
        logic [PKT_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_pkt_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[31:21] == HALT_OPC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch packets with a flush that
// overrides push; push while full is accepted only together with a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_pkt_t       din,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fetch_pkt_t       head
);

    fetch_pkt_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !flush && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; count/pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential 4-byte fetches into a prefetch queue,
// valid/ready towards decode, branch redirect flush and HALT stop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               align_err,
    output logic               halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] tag_pc;
    logic              inflight;
    logic              halt_seen;
    logic              halted_q;

    logic              redir;
    logic              issue;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    fetch_pkt_t        push_pkt;
    fetch_pkt_t        head;

    // Once halted the stage is frozen, so a late redirect must not restart it.
    assign redir     = redirect && !halted_q && !reset;
    // In-flight requests reserve a slot so the response always fits.
    assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
    assign issue     = !reset && !redirect && !halt_seen && !halted_q && !fifo_full
                       && (occupancy < (CNT_W+1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign out_valid = !fifo_empty && !halted_q && !reset;
    assign out_pc    = head.pc[ADDR_W-1:0];
    assign out_instr = head.instr;
    assign pop       = out_valid && out_ready;
    assign align_err = redir && (redirect_pc[1:0] != 2'b00);
    assign halted    = halted_q;

    assign push_pkt.pc    = PKT_ADDR_W'(tag_pc);
    assign push_pkt.instr = imem_rdata;

    // A response landing in the redirect cycle is dropped by the flush itself.
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .flush (redir),
        .din   (push_pkt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            tag_pc    <= RESET_PC;
            inflight  <= 1'b0;
            halt_seen <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue)
                tag_pc <= fetch_pc;

            if (redir)
                fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            else if (issue)
                fetch_pc <= fetch_pc + ADDR_W'(4);

            if (redir)
                halt_seen <= 1'b0;
            else if (inflight && is_halt(imem_rdata))
                halt_seen <= 1'b1;

            if (pop && is_halt(head.instr))
                halted_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a one-cycle-latency IMem model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, redirect, out_valid, out_ready, align_err, halted;
    logic [63:0] imem_addr, redirect_pc, out_pc;
    logic [31:0] imem_rdata = '0, out_instr;

    logic        b_imem_req, b_out_valid, b_align_err, b_halted;
    logic        b_redirect = 1'b0, b_out_ready = 1'b1;
    logic [63:0] b_imem_addr, b_out_pc;
    logic [63:0] b_redirect_pc = '0;
    logic [31:0] b_imem_rdata = '0, b_out_instr;

    logic        halt_at8 = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic [63:0] iss_q[$];
    logic [63:0] acc_pc_q[$];
    logic [31:0] acc_in_q[$];

    always #5 clk = ~clk;

    fetch_queue #(.ADDR_W(64), .DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .align_err(align_err), .halted(halted)
    );

    fetch_queue #(.ADDR_W(64), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_b (
        .clk(clk), .reset(reset), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_rdata(b_imem_rdata), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .out_instr(b_out_instr), .align_err(b_align_err), .halted(b_halted)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h8B02_0020;
        if (a == 64'h4) return 32'h8B03_0041;
        if (a == 64'h8 && halt_at8) return 32'hFFE0_0000;
        return {12'hA00, a[19:0]};
    endfunction

    always @(posedge clk) begin
        if (imem_req)   imem_rdata   <= mem_word(imem_addr);
        if (b_imem_req) b_imem_rdata <= mem_word(b_imem_addr);
        if (imem_req) iss_q.push_back(imem_addr);
        if (out_valid && out_ready) begin
            acc_pc_q.push_back(out_pc);
            acc_in_q.push_back(out_instr);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        iss_q.delete();
        acc_pc_q.delete();
        acc_in_q.delete();
    endtask

    // One reset edge, then release; returns #1 into cycle 0.
    task automatic restart();
        @(negedge clk);
        reset    = 1'b1;
        redirect = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int stale;
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;

        // Reset state and first packets, plus the wrap-around instance.
        @(negedge clk); @(negedge clk); #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", out_valid, 0);
        check("rst_align", align_err, 0);
        check("rst_halted", halted, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        #1;
        check("c0_req", imem_req, 1);
        check("c0_addr", imem_addr, 64'h0);
        check("b_c0_addr", b_imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        check("c1_valid", out_valid, 0);
        step();
        check("c2_valid", out_valid, 1);
        check("c2_pc", out_pc, 64'h0);
        check("c2_instr", out_instr, 32'h8B02_0020);
        check("b_c2_pc", b_out_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        step();
        check("c3_pc", out_pc, 64'h4);
        check("c3_instr", out_instr, 32'h8B03_0041);
        check("b_c3_pc", b_out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("b_c4_pc", b_out_pc, 64'h0);
        check("b_c4_instr", b_out_instr, 32'h8B02_0020);

        // Backpressure: exactly DEPTH issues, then drain without gaps.
        out_ready = 1'b0;
        restart();
        repeat (10) step();
        check("bp_issues", iss_q.size(), 4);
        for (int i = 0; i < 4; i++) check("bp_issue_addr", iss_q[i], 64'(4 * i));
        check("bp_req", imem_req, 0);
        check("bp_count", dut.u_fifo.count, 4);
        check("bp_hold_pc", out_pc, 64'h0);
        out_ready = 1'b1;
        #1;
        repeat (6) step();
        check("drain_n", acc_pc_q.size(), 6);
        for (int i = 0; i < 6; i++) check("drain_pc", acc_pc_q[i], 64'(4 * i));
        check("drain_in2", acc_in_q[2], 32'hA000_0008);
        check("drain_in4", acc_in_q[4], 32'hA000_0010);

        // Redirect with a packed queue and a request in flight.
        out_ready = 1'b0;
        restart();
        repeat (4) step();
        check("rd_inflight", dut.inflight, 1);
        check("rd_count", dut.u_fifo.count, 3);
        redirect = 1'b1; redirect_pc = 64'h40; out_ready = 1'b1;
        clear_logs();
        #1;
        check("rd_align0", align_err, 0);
        check("rd_noissue", imem_req, 0);
        step();
        redirect = 1'b0;
        #1;
        check("rd_n1_req", imem_req, 1);
        check("rd_n1_addr", imem_addr, 64'h40);
        check("rd_n1_valid", out_valid, 0);
        step();
        check("rd_n2_valid", out_valid, 0);
        step();
        check("rd_n3_valid", out_valid, 1);
        check("rd_n3_pc", out_pc, 64'h40);
        check("rd_n3_instr", out_instr, 32'hA000_0040);
        repeat (4) step();
        check("rd_acc_n", acc_pc_q.size(), 5);
        check("rd_acc0", acc_pc_q[0], 64'h0);
        stale = 0;
        for (int i = 1; i < acc_pc_q.size(); i++)
            if (acc_pc_q[i] != 64'h40 + 64'(4 * (i - 1))) stale++;
        check("rd_stale", stale, 0);

        // Misaligned redirect target.
        out_ready = 1'b1;
        restart();
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 64'h42;
        #1;
        check("al_pulse", align_err, 1);
        check("al_noissue", imem_req, 0);
        step();
        redirect = 1'b0;
        #1;
        check("al_pulse_end", align_err, 0);
        check("al_addr", imem_addr, 64'h40);
        step(); step();
        check("al_pc", out_pc, 64'h40);

        // HALT at 0x8: stop fetching, halt on its dequeue, ignore redirects.
        halt_at8 = 1'b1;
        out_ready = 1'b1;
        restart();
        repeat (8) step();
        check("h_issues", iss_q.size(), 4);
        check("h_last_issue", iss_q[3], 64'hC);
        check("h_acc_n", acc_pc_q.size(), 3);
        check("h_acc_pc", acc_pc_q[2], 64'h8);
        check("h_acc_in", acc_in_q[2], 32'hFFE0_0000);
        check("h_halted", halted, 1);
        check("h_valid", out_valid, 0);
        redirect = 1'b1; redirect_pc = 64'h82;
        #1;
        check("h_rd_align", align_err, 0);
        step();
        redirect = 1'b0;
        #1;
        repeat (3) step();
        check("h_rd_req", imem_req, 0);
        check("h_rd_issues", iss_q.size(), 4);
        check("h_rd_halted", halted, 1);
        check("h_rd_valid", out_valid, 0);

        // HALT enqueued but redirected away before decode takes it.
        out_ready = 1'b0;
        restart();
        repeat (6) step();
        check("hw_seen", dut.halt_seen, 1);
        check("hw_halted0", halted, 0);
        check("hw_issues", iss_q.size(), 4);
        redirect = 1'b1; redirect_pc = 64'h40; out_ready = 1'b1;
        clear_logs();
        #1;
        step();
        redirect = 1'b0;
        #1;
        check("hw_req", imem_req, 1);
        check("hw_addr", imem_addr, 64'h40);
        step(); step();
        check("hw_pc", out_pc, 64'h40);
        repeat (3) step();
        check("hw_halted", halted, 0);
        check("hw_seen_clr", dut.halt_seen, 0);
        check("hw_acc_n", acc_pc_q.size(), 4);
        check("hw_acc1", acc_pc_q[1], 64'h40);
        halt_at8 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
